tcp_tx_rt_sched: RTL

//  TX-side retransmit scheduler; the send-side counterpart of the RX ack/dup-ack state tracking.

---
 rtl/tcp_tx_rt_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tcp_tx_rt_sched.sv
// TX retransmit scheduler: per-flow RT timers plus dup-ack fast retransmit, one request at a time.
// Optional exponential backoff of the timeout is enabled by defining RT_BACKOFF_EN.
module tcp_tx_rt_sched #(
    parameter int unsigned MAX_FLOW_CNT      = 8,
    parameter int unsigned FLOWID_W          = 3,
    parameter int unsigned TIMESTAMP_W       = 64,
    parameter int unsigned RT_TIMEOUT_CYCLES = 250000000,
    parameter int unsigned DUP_ACK_CNT_W     = 4,
    parameter int unsigned DUP_ACK_RT        = 3,
    parameter int unsigned ACK_NUM_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm_val,
    input  logic [FLOWID_W-1:0]      arm_flowid,
    input  logic                     ack_val,
    input  logic [FLOWID_W-1:0]      ack_flowid,
    input  logic [ACK_NUM_W-1:0]     ack_num,
    input  logic [DUP_ACK_CNT_W-1:0] ack_dup_cnt,
    input  logic                     ack_all_acked,
    output logic                     rt_req_val,
    output logic [FLOWID_W-1:0]      rt_req_flowid,
    output logic [ACK_NUM_W-1:0]     rt_req_seq,
    output logic                     rt_req_fast,
    input  logic                     rt_req_rdy,
    output logic [TIMESTAMP_W-1:0]   curr_time
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [DUP_ACK_CNT_W-1:0] DUP_RT = DUP_ACK_CNT_W'(DUP_ACK_RT);

    state_t                  state;
    logic [MAX_FLOW_CNT-1:0] armed, pending, pend_fast, fast_done;
    logic [TIMESTAMP_W-1:0]  deadline [MAX_FLOW_CNT];
    logic [ACK_NUM_W-1:0]    last_ack [MAX_FLOW_CNT];
    logic [FLOWID_W-1:0]     scan_ptr, rr_ptr;
    logic                    sel_found;
    logic [FLOWID_W-1:0]     sel_flow, sel_idx;
    logic                    ack_adv, ack_presented, ack_clear_same_arm, scan_blocked;
    logic [2:0]              arm_shift, hs_shift;
`ifdef RT_BACKOFF_EN
    logic [2:0]              shift [MAX_FLOW_CNT];
`endif

    function automatic logic [TIMESTAMP_W-1:0] tmo(input logic [2:0] sh);
        return TIMESTAMP_W'(RT_TIMEOUT_CYCLES) << sh;
    endfunction

    // Lowest pending flow at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_flow  = '0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < MAX_FLOW_CNT; i++) begin
            sel_idx = rr_ptr + FLOWID_W'(i);
            if (!sel_found && pending[sel_idx]) begin
                sel_found = 1'b1;
                sel_flow  = sel_idx;
            end
        end
    end

    always_comb begin
        ack_adv            = ack_num != last_ack[ack_flowid];
        ack_presented      = (state == REQ) && (rt_req_flowid == ack_flowid);
        ack_clear_same_arm = ack_val && ack_all_acked && (ack_flowid == arm_flowid);
        scan_blocked       = ack_val && (ack_flowid == scan_ptr) && (ack_all_acked || ack_adv);
`ifdef RT_BACKOFF_EN
        arm_shift = ack_clear_same_arm ? 3'd0 : shift[arm_flowid];
        hs_shift  = rt_req_fast ? shift[rt_req_flowid]
                  : (shift[rt_req_flowid] == 3'd6) ? 3'd6 : shift[rt_req_flowid] + 3'd1;
`else
        arm_shift = 3'd0;
        hs_shift  = 3'd0;
`endif
    end

    // Update order within a cycle: scan, then handshake, then ack, then arm; later writes win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rt_req_val    <= 1'b0;
            rt_req_flowid <= '0;
            rt_req_seq    <= '0;
            rt_req_fast   <= 1'b0;
            curr_time     <= '0;
            scan_ptr      <= '0;
            rr_ptr        <= '0;
            armed         <= '0;
            pending       <= '0;
            pend_fast     <= '0;
            fast_done     <= '0;
            deadline      <= '{default: '0};
            last_ack      <= '{default: '0};
`ifdef RT_BACKOFF_EN
            shift         <= '{default: '0};
`endif
        end else begin
            curr_time <= curr_time + TIMESTAMP_W'(1);
            scan_ptr  <= scan_ptr + FLOWID_W'(1);

            if (armed[scan_ptr] && !pending[scan_ptr] && !scan_blocked &&
                curr_time >= deadline[scan_ptr]) begin
                pending[scan_ptr]   <= 1'b1;
                pend_fast[scan_ptr] <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        rt_req_val    <= 1'b1;
                        rt_req_flowid <= sel_flow;
                        rt_req_seq    <= last_ack[sel_flow];
                        rt_req_fast   <= pend_fast[sel_flow];
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (rt_req_rdy) begin
                        rt_req_val              <= 1'b0;
                        pending[rt_req_flowid]  <= 1'b0;
                        deadline[rt_req_flowid] <= curr_time + tmo(hs_shift);
                        rr_ptr                  <= rt_req_flowid + FLOWID_W'(1);
                        state                   <= IDLE;
`ifdef RT_BACKOFF_EN
                        shift[rt_req_flowid]    <= hs_shift;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            if (ack_val) begin
                if (ack_all_acked) begin
                    armed[ack_flowid] <= 1'b0;
                    if (!ack_presented) begin
                        pending[ack_flowid]   <= 1'b0;
                        fast_done[ack_flowid] <= 1'b0;
                    end
`ifdef RT_BACKOFF_EN
                    shift[ack_flowid] <= 3'd0;
`endif
                end
                if (ack_adv) begin
                    last_ack[ack_flowid]  <= ack_num;
                    deadline[ack_flowid]  <= curr_time + tmo(3'd0);
                    fast_done[ack_flowid] <= 1'b0;
`ifdef RT_BACKOFF_EN
                    shift[ack_flowid]     <= 3'd0;
`endif
                end
                // An advancing ack re-opens fast RT in the same cycle it arrives.
                if (!ack_all_acked && ack_dup_cnt == DUP_RT &&
                    (ack_adv || !fast_done[ack_flowid])) begin
                    pending[ack_flowid]   <= 1'b1;
                    pend_fast[ack_flowid] <= 1'b1;
                    fast_done[ack_flowid] <= 1'b1;
                end
            end

            if (arm_val && !(armed[arm_flowid] && !ack_clear_same_arm)) begin
                armed[arm_flowid]    <= 1'b1;
                deadline[arm_flowid] <= curr_time + tmo(arm_shift);
            end
        end
    end
endmodule
